// File: rtl/call_dispatch_scheduler_if.sv
// Station-side bus of the call dispatch scheduler.
// master: the call-station panel (drives call/cancel, observes the indicators).
// slave : the scheduler (samples call/cancel, drives lights and attendant status).
interface call_dispatch_scheduler_if #(
  parameter int N_STATIONS = 4,
  parameter int IDW        = $clog2(N_STATIONS)
);
  logic [N_STATIONS-1:0] call;
  logic [N_STATIONS-1:0] cancel;
  logic [N_STATIONS-1:0] light;
  logic                  busy;
  logic                  target_valid;
  logic [IDW-1:0]        target;
  logic                  arrived;
  logic                  done;

  modport master (
    output call, cancel,
    input  light, busy, target_valid, target, arrived, done
  );

  modport slave (
    input  call, cancel,
    output light, busy, target_valid, target, arrived, done
  );
endinterface

// File: rtl/call_dispatch_scheduler.sv
// Call dispatch scheduler: one attendant shared by N_STATIONS call stations.
// Each station owns a call light (call sets it, cancel clears it unless call is
// also high). A round-robin arbiter picks a lit station in IDLE, the attendant
// spends TRAVEL_CYCLES travelling and SERVE_CYCLES serving, and the served
// station's light is cleared as the done cycle ends.
// A cancel while travelling aborts the dispatch; a cancel while serving does not.
// Optional build macro STATION0_PRIORITY_EN: station 0 pre-empts the round-robin
// order whenever its light is set, and serving it leaves the pointer untouched.
module call_dispatch_scheduler #(
  parameter int N_STATIONS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int SERVE_CYCLES  = 4,
  parameter int IDW           = $clog2(N_STATIONS)
) (
  input  logic                     clk,
  input  logic                     reset,
  call_dispatch_scheduler_if.slave bus
);

  // Counter only has to hold 0 .. max(TRAVEL_CYCLES, SERVE_CYCLES)-1.
  localparam int MAXC = (TRAVEL_CYCLES > SERVE_CYCLES) ? TRAVEL_CYCLES : SERVE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    SERVE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [N_STATIONS-1:0] light_q;
  logic [N_STATIONS-1:0] light_next;
  logic [IDW-1:0]        target_q;
  logic [IDW-1:0]        ptr_q;
  logic [CW-1:0]         cnt_q;

  logic                  rr_valid;
  logic [IDW-1:0]        rr_idx;
  logic                  pick_valid;
  logic [IDW-1:0]        pick_idx;

  logic                  target_lit;
  logic                  travel_last;
  logic                  serve_last;
  logic                  done_now;

  assign target_lit  = light_q[target_q];
  assign travel_last = (cnt_q == CW'(TRAVEL_CYCLES - 1));
  assign serve_last  = (cnt_q == CW'(SERVE_CYCLES - 1));
  assign done_now    = (state == SERVE) && serve_last;

  // Station index k positions after base, wrapping modulo N_STATIONS.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N_STATIONS);
  endfunction

  // Round-robin search: first lit station from ptr+1 upward, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= N_STATIONS; k++) begin
      if (!rr_valid && light_q[rr_index(ptr_q, k)]) begin
        rr_valid = 1'b1;
        rr_idx   = rr_index(ptr_q, k);
      end
    end
  end

  // Final pick: optionally let station 0 pre-empt the round-robin choice.
  always_comb begin
    pick_valid = rr_valid;
    pick_idx   = rr_idx;
`ifdef STATION0_PRIORITY_EN
    if (light_q[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  // Light update: call dominates cancel and the service clear at done.
  always_comb begin
    light_next = '0;
    for (int i = 0; i < N_STATIONS; i++) begin
      light_next[i] = bus.call[i]
                    | (light_q[i] & ~bus.cancel[i] & ~(done_now && (target_q == IDW'(i))));
    end
  end

  // Call light register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      light_q <= '0;
    end else begin
      light_q <= light_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: dispatch from IDLE, abort TRAVEL on a dark target light.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (pick_valid) state_next = TRAVEL;
      end
      TRAVEL: begin
        if (!target_lit)      state_next = IDLE;
        else if (travel_last) state_next = SERVE;
      end
      SERVE: begin
        if (serve_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Dispatch datapath: target capture, phase counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      ptr_q    <= IDW'(N_STATIONS - 1);
      cnt_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_q <= '0;
          if (pick_valid) target_q <= pick_idx;
        end
        TRAVEL: begin
          // Counter restarts at 0 both on entry to SERVE and on abort.
          if (target_lit && !travel_last) cnt_q <= cnt_q + 1'b1;
          else                            cnt_q <= '0;
        end
        SERVE: begin
          if (!serve_last) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
`ifdef STATION0_PRIORITY_EN
            // Station 0 sits outside the rotation, so serving it keeps the pointer.
            if (target_q != '0) ptr_q <= target_q;
`else
            ptr_q <= target_q;
`endif
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // FSM outputs, decoded from registered state and counter only.
  always_comb begin
    bus.busy         = (state != IDLE);
    bus.target_valid = (state == TRAVEL) || (state == SERVE);
    bus.arrived      = (state == SERVE) && (cnt_q == '0);
    bus.done         = done_now;
  end

  assign bus.light  = light_q;
  assign bus.target = target_q;

endmodule
